// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IRESP = 2'd1,
    DRESP = 2'd2
  } arb_state_e;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  function automatic int starve_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Avalon-MM style read/write bus bundle
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            read;
  logic            write;
  logic [AW-1:0]   address;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic            waitrequest;
  logic            rvalid;
  logic [DW-1:0]   readdata;

  modport master (
    output read, write, address, writedata, byteenable,
    input  waitrequest, rvalid, readdata
  );

  modport slave (
    input  read, write, address, writedata, byteenable,
    output waitrequest, rvalid, readdata
  );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// rtl/mem_port_arbiter_arb_pick.sv - two-way priority select, dbus first unless ibus is starved
module arb_pick (
  input  logic ibus_req,
  input  logic dbus_req,
  input  logic starved,
  output logic grant_i,
  output logic grant_d
);

  assign grant_i = ibus_req & (~dbus_req | starved);
  assign grant_d = dbus_req & ~grant_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data buses
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   ibus,
  mem_port_arbiter_if.slave   dbus,
  mem_port_arbiter_if.master  mbus
);

  localparam int            CW    = starve_w(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          dbus_req;
  logic          starved;
  logic          grant_i, grant_d;

  assign dbus_req = dbus.read | dbus.write;
  assign starved  = (starve_q == LIMIT);

  arb_pick u_pick (
    .ibus_req (ibus.read),
    .dbus_req (dbus_req),
    .starved  (starved),
    .grant_i  (grant_i),
    .grant_d  (grant_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    starve_d         = starve_q;
    mbus.read        = 1'b0;
    mbus.write       = 1'b0;
    mbus.address     = '0;
    mbus.writedata   = '0;
    mbus.byteenable  = '0;
    ibus.waitrequest = 1'b1;
    dbus.waitrequest = 1'b1;
    ibus.rvalid      = 1'b0;
    ibus.readdata    = '0;
    dbus.rvalid      = 1'b0;
    dbus.readdata    = '0;

    // Outputs are held at their reset values for as long as rst is high.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (grant_i) begin
            mbus.read        = 1'b1;
            mbus.address     = ibus.address;
            mbus.byteenable  = '1;
            ibus.waitrequest = mbus.waitrequest;
            if (!mbus.waitrequest) begin
              state_d  = IRESP;
              starve_d = '0;
            end
          end else if (grant_d) begin
            mbus.read        = dbus.read;
            mbus.write       = dbus.write;
            mbus.address     = dbus.address;
            mbus.writedata   = dbus.writedata;
            mbus.byteenable  = dbus.byteenable;
            dbus.waitrequest = mbus.waitrequest;
            if (!mbus.waitrequest) begin
              if (dbus.read) state_d = DRESP;
              if (ibus.read && !starved) starve_d = starve_q + CW'(1);
            end
          end
        end
        IRESP: begin
          if (mbus.rvalid) begin
            ibus.rvalid   = 1'b1;
            ibus.readdata = mbus.readdata;
            state_d       = IDLE;
          end
        end
        DRESP: begin
          if (mbus.rvalid) begin
            dbus.rvalid   = 1'b1;
            dbus.readdata = mbus.readdata;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // Starvation only counts while a fetch is actually waiting.
      if (!ibus.read) starve_d = '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) ibus ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) dbus ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) mbus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk  (clk),
    .rst  (rst),
    .ibus (ibus),
    .dbus (dbus),
    .mbus (mbus)
  );

  int checks = 0;
  int errors = 0;
  // Reference model: owner 0 = none, 1 = ibus, 2 = dbus.
  int m_owner = 0, m_starve = 0;
  int n_owner = 0, n_starve = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ibus.read = 0; ibus.write = 0; ibus.address = 0; ibus.writedata = 0; ibus.byteenable = 0;
    dbus.read = 0; dbus.write = 0; dbus.address = 0; dbus.writedata = 0; dbus.byteenable = 0;
    mbus.waitrequest = 0; mbus.rvalid = 0; mbus.readdata = 0;
  endtask

  // Mid-cycle: predict outputs from the arbitration rules and compare.
  task automatic settle();
    logic [69:0] e_cmd;
    logic [1:0]  e_wait;
    logic [65:0] e_resp;
    bit dreq, win_i, win_d;
    #4;
    e_cmd = '0; e_wait = 2'b11; e_resp = '0;
    n_owner = m_owner; n_starve = m_starve;
    if (rst) begin
      n_owner = 0; n_starve = 0;
    end else begin
      if (m_owner == 0) begin
        dreq  = dbus.read || dbus.write;
        win_i = ibus.read && (!dreq || m_starve == LIM);
        win_d = dreq && !win_i;
        if (win_i) begin
          e_cmd = {1'b1, 1'b0, ibus.address, 32'h0, 4'hF};
          e_wait[1] = mbus.waitrequest;
          if (!mbus.waitrequest) begin n_owner = 1; n_starve = 0; end
        end else if (win_d) begin
          e_cmd = {dbus.read, dbus.write, dbus.address, dbus.writedata, dbus.byteenable};
          e_wait[0] = mbus.waitrequest;
          if (!mbus.waitrequest) begin
            if (dbus.read) n_owner = 2;
            if (ibus.read) n_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
          end
        end
      end else if (mbus.rvalid) begin
        if (m_owner == 1) e_resp = {1'b1, mbus.readdata, 1'b0, 32'h0};
        else              e_resp = {1'b0, 32'h0, 1'b1, mbus.readdata};
        n_owner = 0;
      end
      if (!ibus.read) n_starve = 0;
    end
    chk("mbus_cmd", {mbus.read, mbus.write, mbus.address, mbus.writedata, mbus.byteenable}, e_cmd);
    chk("waitrequest", {ibus.waitrequest, dbus.waitrequest}, e_wait);
    chk("response", {ibus.rvalid, ibus.readdata, dbus.rvalid, dbus.readdata}, e_resp);
  endtask

  task automatic tick();
    @(posedge clk);
    m_owner  = n_owner;
    m_starve = n_starve;
    #1;
    chk("starve_cnt", dut.starve_q, m_starve);
  endtask

  initial begin
    int nwrites;
    bit granted;
    clear_inputs();
    #1;

    // Reset values
    rst = 1;
    ibus.read = 1; dbus.read = 1; dbus.address = 32'h55; mbus.rvalid = 1; mbus.readdata = 32'h1234;
    settle();
    chk("rst_mbus_read", mbus.read, 0);
    chk("rst_waits", {ibus.waitrequest, dbus.waitrequest}, 2'b11);
    tick();
    clear_inputs();
    rst = 0;
    settle(); tick();

    // Lone fetch
    ibus.read = 1; ibus.address = 32'h100;
    settle();
    chk("fetch_cmd", {mbus.read, mbus.address}, {1'b1, 32'h100});
    tick();
    ibus.read = 0;
    settle(); tick();
    mbus.rvalid = 1; mbus.readdata = 32'hDEADBEEF;
    settle();
    chk("fetch_resp", {ibus.rvalid, ibus.readdata, dbus.rvalid}, {1'b1, 32'hDEADBEEF, 1'b0});
    tick();
    clear_inputs();

    // Contention: dbus first, ibus after dbus response
    ibus.read = 1; ibus.address = 32'h300; dbus.read = 1; dbus.address = 32'h200;
    settle();
    chk("cont_dfirst", {mbus.address, ibus.waitrequest, dbus.waitrequest}, {32'h200, 1'b1, 1'b0});
    tick();
    dbus.read = 0; mbus.rvalid = 1; mbus.readdata = 32'hA5A5_0001;
    settle();
    chk("cont_dresp", {dbus.rvalid, ibus.waitrequest}, {1'b1, 1'b1});
    tick();
    mbus.rvalid = 0;
    settle();
    chk("cont_igrant", {mbus.address, ibus.waitrequest}, {32'h300, 1'b0});
    tick();
    ibus.read = 0; mbus.rvalid = 1;
    settle(); tick();
    clear_inputs();
    settle(); tick();

    // Starvation: posted writes against a held fetch
    ibus.read = 1; ibus.address = 32'h400; dbus.write = 1; dbus.address = 32'h80;
    dbus.writedata = 32'hCAFE; dbus.byteenable = 4'h3;
    nwrites = 0; granted = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (!ibus.waitrequest) begin granted = 1; break; end
      if (!dbus.waitrequest) nwrites++;
      dbus.writedata = dbus.writedata + 1;
      tick();
    end
    chk("starve_writes", nwrites, 4);
    chk("starve_granted", granted, 1);
    chk("starve_sat", dut.starve_q, 4);
    tick();
    chk("starve_clear", dut.starve_q, 0);
    ibus.read = 0; dbus.write = 0; mbus.rvalid = 1; mbus.readdata = 32'h77;
    settle(); tick();
    clear_inputs();

    // Memory backpressure during dbus read
    dbus.read = 1; dbus.address = 32'h500; mbus.waitrequest = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_hold", {dbus.waitrequest, mbus.read, mbus.address}, {1'b1, 1'b1, 32'h500});
      tick();
    end
    mbus.waitrequest = 0;
    settle();
    chk("bp_accept", dbus.waitrequest, 0);
    tick();
    dbus.read = 0; mbus.rvalid = 1; mbus.readdata = 32'h5;
    settle(); tick();
    clear_inputs();

    // Reset in IRESP, stray rvalid afterwards
    ibus.read = 1; ibus.address = 32'h600;
    settle(); tick();
    ibus.read = 0; rst = 1;
    settle();
    chk("rst_iresp", {mbus.read, ibus.waitrequest, ibus.rvalid}, {1'b0, 1'b1, 1'b0});
    tick();
    rst = 0; mbus.rvalid = 1; mbus.readdata = 32'hBAD;
    settle();
    chk("stray_rvalid", {ibus.rvalid, dbus.rvalid}, 2'b00);
    tick();
    mbus.rvalid = 0; ibus.read = 1; ibus.address = 32'h700;
    settle();
    chk("post_rst_grant", {ibus.waitrequest, mbus.address}, {1'b0, 32'h700});
    tick();
    ibus.read = 0; mbus.rvalid = 1;
    settle(); tick();
    clear_inputs();

    // Write then read on consecutive cycles
    dbus.write = 1; dbus.address = 32'h900; dbus.writedata = 32'h11; dbus.byteenable = 4'hF;
    settle();
    chk("wr_accept", dbus.waitrequest, 0);
    tick();
    chk("wr_state", dut.state_q, IDLE);
    dbus.write = 0; dbus.read = 1; dbus.address = 32'h904;
    settle();
    chk("rd_accept", dbus.waitrequest, 0);
    tick();
    chk("rd_state", dut.state_q, DRESP);
    dbus.read = 0; mbus.rvalid = 1; mbus.readdata = 32'h22;
    settle(); tick();
    clear_inputs();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      int kind;
      rst = ($urandom_range(0, 99) == 0);
      ibus.read = 1'($urandom_range(0, 1));
      ibus.address = $urandom;
      kind = $urandom_range(0, 2);
      dbus.read = (kind == 1);
      dbus.write = (kind == 2);
      dbus.address = $urandom;
      dbus.writedata = $urandom;
      dbus.byteenable = 4'($urandom);
      mbus.waitrequest = ($urandom_range(0, 3) == 0);
      mbus.rvalid = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      mbus.readdata = $urandom;
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one Avalon-MM memory port between the IF-stage instruction bus (ibus) and the MEM-stage data bus (dbus) in a single-port-memory configuration of the core. Data accesses win by default; a starvation counter guarantees fetch progress. Each requester sees waitrequest, which feeds the core's load/fetch stall logic, so the hazard unit sees a shared-port conflict as an ordinary stall. One outstanding read at a time; the response is routed back by the recorded owner.

## Interface
- AW, 32, address width
- DW, 32, data width (byte enables DW/8)
- STARVE_LIMIT, 4, consecutive dbus grants with ibus pending before ibus is forced ahead (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ibus_read / ibus_address  in  1 / AW  fetch request
- ibus_waitrequest  out  1  fetch request not accepted this cycle
- ibus_rvalid / ibus_readdata  out  1 / DW  fetch response
- dbus_read / dbus_write  in  1 / 1  data request (never both high)
- dbus_address / dbus_writedata / dbus_byteenable  in  AW / DW / DW/8
- dbus_waitrequest  out  1;  dbus_rvalid / dbus_readdata  out  1 / DW
- mbus_read / mbus_write  out  1 / 1;  mbus_address / mbus_writedata / mbus_byteenable  out  AW / DW / DW/8
- mbus_waitrequest  in  1;  mbus_rvalid / mbus_readdata  in  1 / DW

## Operation
- States: IDLE, IRESP (ibus read accepted, awaiting rvalid), DRESP (dbus read accepted, awaiting rvalid).
- IDLE arbitration, combinational from current requests: only one requesting → it wins; both → dbus wins unless starve_cnt == STARVE_LIMIT, then ibus wins.
- Winner's command, address, data and byteenable drive mbus_* the same cycle; the loser sees waitrequest=1. The winner's waitrequest = mbus_waitrequest.
- Accepted (mbus_waitrequest=0): ibus read → IRESP; dbus read → DRESP; dbus write → stay IDLE (posted, no response).
- Not accepted: stay IDLE and re-arbitrate next cycle. Requesters hold their requests per Avalon rules, so the same winner is normally re-picked. Starve_cnt does not change on unaccepted cycles.
- IRESP/DRESP: all mbus command outputs 0; both waitrequests 1. mbus_rvalid → owner's rvalid=1 and readdata=mbus_readdata the same cycle, then → IDLE.
- rvalid routing is purely by state. Non-owner rvalid is always 0. mbus_rvalid in IDLE is dropped.
- readdata outputs are mbus_readdata when the matching rvalid is 1, else 0.
- starve_cnt (width $clog2(STARVE_LIMIT+1)):
  - increments on each accepted dbus command while ibus_read=1;
  - clears on an accepted ibus read or any cycle with ibus_read=0;
  - saturates at STARVE_LIMIT.
- Reset: state=IDLE, starve_cnt=0. While rst=1: mbus_read=mbus_write=0, mbus_address/writedata/byteenable=0, both waitrequest=1, both rvalid=0, readdata=0.
- Reset mid-transaction abandons the outstanding read; a late mbus_rvalid arriving in IDLE is dropped.

## Timing
- Grant latency 0: a request in IDLE with an idle memory is accepted the same cycle.
- Read: accept at cycle N; response in the cycle mbus_rvalid rises (≥N+1). Next accept is no earlier than the cycle after rvalid.
- Back-to-back posted dbus writes: one per cycle.
- Fixed read occupancy is 1 accept cycle + memory latency + 0 turnaround.
- Simultaneous rvalid and a new request in a RESP state: the request waits (waitrequest=1) and is arbitrated next cycle in IDLE.

## Structure
- Add the state enum (arb_state_e: IDLE, IRESP, DRESP) and the STARVE_LIMIT default to core.svh alongside the other core definitions.
- One sub-module: arb_pick (combinational two-way priority select with starvation override; inputs ibus_req, dbus_req, starved; outputs grant_i, grant_d).
- The FSM, counter and muxes stay in mem_port_arbiter.

## Test plan
- Lone fetch: ibus_read=1, address 0x100, mbus_waitrequest=0, rvalid 2 cycles later with data 0xDEADBEEF. Required: mbus_read=1 with address 0x100 in cycle 0; ibus_rvalid=1 with 0xDEADBEEF in cycle 2; dbus_rvalid stays 0.
- Contention: ibus_read and dbus_read both held, address 0x200 (dbus). Required: dbus is granted first (mbus_address=0x200, ibus_waitrequest=1); ibus is granted in the IDLE cycle after dbus_rvalid.
- Starvation, STARVE_LIMIT=4: dbus issues continuous posted writes while ibus_read is held. Required: exactly 4 dbus writes accepted, the 5th grant goes to ibus, starve_cnt returns to 0.
- Memory backpressure: mbus_waitrequest=1 for 3 cycles during a dbus read. Required: dbus_waitrequest=1 for those 3 cycles, the command is stable on mbus, and it is accepted on the 4th cycle.
- Reset in IRESP: assert rst for 1 cycle, then mbus_rvalid arrives. Required: all outputs at reset values during rst; the stray rvalid produces no ibus_rvalid or dbus_rvalid; the next request is granted normally.
- Write then read: dbus_write accepted in cycle 0, dbus_read in cycle 1. Required: both accepted on consecutive cycles; the state moves IDLE→IDLE→DRESP.
